mux3_rr_sel: RTL and testbench
==============================

Name: mux3_rr_sel

Overview:
- Three-way round-robin burst arbiter. Generates the 2-bit select for the downstream two-stage 3:1 mux built from MUX2_74LVC1G157 cells, one mux per data bit.
- Owns no data path. It decides which of three requesters drives the shared bus, holds that choice for a whole burst, and runs the valid/ready handshake toward the consumer.
- Select, grant and state are registered, so the mux select lines never glitch.

Parameters:
- MAX_BURST, default 0: maximum beats per grant. 0 means unlimited; release happens only on last_i.
- CNT_W, default 4: beat counter width. Must satisfy 2**CNT_W >= MAX_BURST.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge
- rst_i  input  1  synchronous active-high reset
- req_i  input  3  per-channel valid/request
- last_i  input  3  per-channel last-beat flag; sampled only on a handshake of the granted channel
- gnt_o  output  3  one-hot grant, registered
- sel_o  output  2  mux select, registered: ch0=2'b00, ch1=2'b01, ch2=2'b10; 2'b11 is never driven
- valid_o  output  1  downstream valid
- ready_i  input  1  downstream ready
- beat_o  output  CNT_W  beats completed in the current burst, registered

Behaviour:
- State and reset
  - States are IDLE and BUSY.
  - On rst_i=1 at a clock edge: state=IDLE, priority pointer ptr=0, gnt_o=3'b000, sel_o=2'b00, beat_o=0, granted index k=0.
  - Reset mid-burst aborts the burst with no release bookkeeping. ptr still returns to 0.
- Derived signals
  - valid_o = (state==BUSY) & req_i[k]. This is the only combinational output.
  - Handshake hs = valid_o & ready_i.
- IDLE
  - gnt_o=0. sel_o holds its last value.
  - If req_i != 0, pick the first set request scanning ptr, ptr+1, ptr+2 (mod 3).
  - Next edge: state=BUSY, k=winner, gnt_o=onehot(k), sel_o=enc(k), beat_o=0.
  - Latency: req_i asserted in cycle n gives gnt_o/sel_o in cycle n+1. valid_o can assert in cycle n+1.
  - If req_i=0, stay in IDLE.
- BUSY
  - Grant is locked to k. Other channels' requests are ignored.
  - If req_i[k] drops, valid_o=0 and the grant is held; no release occurs.
  - On hs without release: beat_o increments. At the wrap to 2**CNT_W-1, beat_o saturates and does not wrap.
  - Release condition: hs & (last_i[k] | (MAX_BURST!=0 & beat_o==MAX_BURST-1)).
  - On release, next edge: state=IDLE, gnt_o=0, ptr=(k+1) mod 3, beat_o=0, sel_o unchanged.
- Throughput
  - Exactly one IDLE bubble cycle between bursts. Max rate is one beat per cycle within a burst.
- Simultaneous events
  - Release and new requests in the same cycle: new requests are arbitrated in the following IDLE cycle using the updated ptr.
  - ready_i=1 with valid_o=0 is not a handshake.
  - last_i on a non-granted channel is ignored.
- Invariants
  - gnt_o is one-hot in BUSY and zero in IDLE.
  - sel_o only changes on the IDLE->BUSY edge.
  - valid_o never asserts in IDLE.

Test Plan:
- Reset/idle: after rst_i, hold req_i=0 for 5 cycles -> gnt_o=000, sel_o=00, valid_o=0, beat_o=0 throughout.
- Single request: req_i=010, ready_i=1, last_i[1] on the 3rd beat -> gnt_o=010 and sel_o=01 in the cycle after req; 3 handshakes; IDLE on the next edge; ptr=2.
- Round-robin fairness: req_i=111 constant, each burst 1 beat with last=1 -> grant sequence ch0,ch1,ch2,ch0 with sel_o 00,01,10,00; one IDLE cycle between each.
- Backpressure/lock: ch2 granted, ready_i=0 for 4 cycles while req_i=111 -> gnt_o stays 100, sel_o=10, beat_o=0, valid_o=1; ready_i=1 then resumes the count.
- Burst limit: MAX_BURST=4, req_i=001, last_i=0, ready_i=1 -> beat_o 0,1,2,3, then release after the 4th handshake; re-grant ch0 after one IDLE cycle.
- Mid-burst events: ch1 granted, beat_o=2, req_i[1] dropped for 2 cycles -> valid_o=0, grant held; then rst_i pulse -> next edge gnt_o=000, sel_o=00, beat_o=0, ptr=0.

Source files
------------

// File: rtl/mux3_rr_sel.sv
// Three-way round-robin burst arbiter driving the select of a two-stage 3:1 mux.
// The winning channel keeps the bus until its burst ends. Grant, select and
// beat count are registered so the mux select lines never glitch.
module mux3_rr_sel #(
    parameter int unsigned MAX_BURST = 0,
    parameter int unsigned CNT_W     = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [2:0]       req_i,
    input  logic [2:0]       last_i,
    output logic [2:0]       gnt_o,
    output logic [1:0]       sel_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [CNT_W-1:0] beat_o
);

    localparam bit             HAS_LIMIT = (MAX_BURST != 0);
    localparam logic [CNT_W-1:0] LIMIT_M1 = HAS_LIMIT ? CNT_W'(MAX_BURST - 1) : '0;
    localparam logic [CNT_W-1:0] BEAT_MAX = '1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       k_q, k_d;
    logic [2:0]       gnt_q, gnt_d;
    logic [1:0]       sel_q, sel_d;
    logic [CNT_W-1:0] beat_q, beat_d;

    logic             valid_c;
    logic             hs_c;
    logic             release_c;
    logic [1:0]       win_c;

    // Valid is the granted channel's request, only while a burst is open.
    assign valid_c   = (state_q == BUSY) && req_i[k_q];
    assign hs_c      = valid_c && ready_i;
    assign release_c = hs_c && (last_i[k_q] || (HAS_LIMIT && (beat_q == LIMIT_M1)));

    // Round-robin pick: first set request scanning ptr, ptr+1, ptr+2 (mod 3).
    always_comb begin
        win_c = 2'd0;
        unique case (ptr_q)
            2'd1:    win_c = req_i[1] ? 2'd1 : (req_i[2] ? 2'd2 : 2'd0);
            2'd2:    win_c = req_i[2] ? 2'd2 : (req_i[0] ? 2'd0 : 2'd1);
            default: win_c = req_i[0] ? 2'd0 : (req_i[1] ? 2'd1 : 2'd2);
        endcase
    end

    // Next-state logic: arbitrate in IDLE, count beats and detect release in BUSY.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        k_d     = k_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        beat_d  = beat_q;

        unique case (state_q)
            IDLE: begin
                gnt_d = 3'b000;
                if (req_i != 3'b000) begin
                    state_d = BUSY;
                    k_d     = win_c;
                    gnt_d   = 3'(3'b001 << win_c);
                    sel_d   = win_c;
                    beat_d  = '0;
                end
            end
            BUSY: begin
                if (release_c) begin
                    state_d = IDLE;
                    gnt_d   = 3'b000;
                    ptr_d   = (k_q == 2'd2) ? 2'd0 : k_q + 2'd1;
                    beat_d  = '0;
                end else if (hs_c && (beat_q != BEAT_MAX)) begin
                    beat_d = beat_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 3'b000;
            end
        endcase
    end

    // State register with synchronous reset; reset aborts any open burst.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            k_q     <= 2'd0;
            gnt_q   <= 3'b000;
            sel_q   <= 2'b00;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            k_q     <= k_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            beat_q  <= beat_d;
        end
    end

    assign gnt_o   = gnt_q;
    assign sel_o   = sel_q;
    assign beat_o  = beat_q;
    assign valid_o = valid_c;

endmodule

// File: tb/tb_mux3_rr_sel.sv
// Directed bench for mux3_rr_sel: an unlimited-burst instance (a) and a
// MAX_BURST=4 instance (b) share the same stimulus.
module tb_mux3_rr_sel;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] req;
    logic [2:0] last;
    logic       ready;

    logic [2:0] gnt_a, gnt_b;
    logic [1:0] sel_a, sel_b;
    logic       valid_a, valid_b;
    logic [3:0] beat_a, beat_b;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mux3_rr_sel #(.MAX_BURST(0), .CNT_W(4)) dut_a (
        .clk_i(clk), .rst_i(rst), .req_i(req), .last_i(last),
        .gnt_o(gnt_a), .sel_o(sel_a), .valid_o(valid_a), .ready_i(ready), .beat_o(beat_a)
    );

    mux3_rr_sel #(.MAX_BURST(4), .CNT_W(4)) dut_b (
        .clk_i(clk), .rst_i(rst), .req_i(req), .last_i(last),
        .gnt_o(gnt_b), .sel_o(sel_b), .valid_o(valid_b), .ready_i(ready), .beat_o(beat_b)
    );

    // Advance one clock; observe 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 3'b000; last = 3'b000; ready = 1'b0;
        step();
        rst = 1'b0;
    endtask

    // Observed bundle is {gnt, sel, valid, beat}.
    task automatic test_reset();
        logic [9:0] exp_v;
        rst = 1'b1; req = 3'b000; last = 3'b000; ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        exp_v = 10'b000_00_0_0000;
        for (int i = 0; i < 5; i++) begin
            step();
            vectors++;
            if ({gnt_a, sel_a, valid_a, beat_a} !== exp_v || {gnt_b, sel_b, valid_b, beat_b} !== exp_v) begin
                miscompares++;
                $display("FAIL reset_idle[%0d]: a=%b b=%b expected %b", i,
                         {gnt_a, sel_a, valid_a, beat_a}, {gnt_b, sel_b, valid_b, beat_b}, exp_v);
            end
        end
    endtask

    task automatic test_single_request();
        logic [9:0] exp_v [5];
        exp_v[0] = 10'b010_01_1_0000;
        exp_v[1] = 10'b010_01_1_0001;
        exp_v[2] = 10'b010_01_1_0010;
        exp_v[3] = 10'b000_01_0_0000;
        exp_v[4] = 10'b100_10_1_0000;
        do_reset();
        req = 3'b010; ready = 1'b1;
        #1;
        vectors++;
        if (valid_a !== 1'b0) begin
            miscompares++;
            $display("FAIL single_idle_valid: got %b expected 0", valid_a);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            vectors++;
            if ({gnt_a, sel_a, valid_a, beat_a} !== exp_v[i]) begin
                miscompares++;
                $display("FAIL single_req[%0d]: got %b expected %b", i, {gnt_a, sel_a, valid_a, beat_a}, exp_v[i]);
            end
            // 3rd beat carries last; others request at the same time so the
            // following IDLE cycle shows the pointer moved to ch2.
            if (i == 2) begin
                last = 3'b010; req = 3'b111;
            end else begin
                last = 3'b000;
            end
        end
    endtask

    task automatic test_round_robin();
        logic [9:0] exp_v [7];
        exp_v[0] = 10'b001_00_1_0000;
        exp_v[1] = 10'b000_00_0_0000;
        exp_v[2] = 10'b010_01_1_0000;
        exp_v[3] = 10'b000_01_0_0000;
        exp_v[4] = 10'b100_10_1_0000;
        exp_v[5] = 10'b000_10_0_0000;
        exp_v[6] = 10'b001_00_1_0000;
        do_reset();
        req = 3'b111; last = 3'b111; ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            vectors++;
            if ({gnt_a, sel_a, valid_a, beat_a} !== exp_v[i] || {gnt_b, sel_b, valid_b, beat_b} !== exp_v[i]) begin
                miscompares++;
                $display("FAIL round_robin[%0d]: a=%b b=%b expected %b", i,
                         {gnt_a, sel_a, valid_a, beat_a}, {gnt_b, sel_b, valid_b, beat_b}, exp_v[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [9:0] exp_v;
        do_reset();
        req = 3'b100; ready = 1'b0;
        step();
        req = 3'b111;
        exp_v = 10'b100_10_1_0000;
        for (int i = 0; i < 4; i++) begin
            step();
            vectors++;
            if ({gnt_a, sel_a, valid_a, beat_a} !== exp_v) begin
                miscompares++;
                $display("FAIL backpressure_hold[%0d]: got %b expected %b", i, {gnt_a, sel_a, valid_a, beat_a}, exp_v);
            end
        end
        // Resume; last on non-granted channels must not release.
        ready = 1'b1; last = 3'b011;
        for (int i = 1; i <= 2; i++) begin
            step();
            exp_v = {3'b100, 2'b10, 1'b1, 4'(i)};
            vectors++;
            if ({gnt_a, sel_a, valid_a, beat_a} !== exp_v) begin
                miscompares++;
                $display("FAIL backpressure_resume[%0d]: got %b expected %b", i, {gnt_a, sel_a, valid_a, beat_a}, exp_v);
            end
        end
        last = 3'b100;
        step();
        exp_v = 10'b000_10_0_0000;
        vectors++;
        if ({gnt_a, sel_a, valid_a, beat_a} !== exp_v) begin
            miscompares++;
            $display("FAIL backpressure_release: got %b expected %b", {gnt_a, sel_a, valid_a, beat_a}, exp_v);
        end
    endtask

    task automatic test_burst_limit();
        logic [9:0] exp_b [6];
        logic [3:0] exp_beat;
        exp_b[0] = 10'b001_00_1_0000;
        exp_b[1] = 10'b001_00_1_0001;
        exp_b[2] = 10'b001_00_1_0010;
        exp_b[3] = 10'b001_00_1_0011;
        exp_b[4] = 10'b000_00_0_0000;
        exp_b[5] = 10'b001_00_1_0000;
        do_reset();
        req = 3'b001; last = 3'b000; ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            vectors++;
            if ({gnt_b, sel_b, valid_b, beat_b} !== exp_b[i]) begin
                miscompares++;
                $display("FAIL burst_limit[%0d]: got %b expected %b", i, {gnt_b, sel_b, valid_b, beat_b}, exp_b[i]);
            end
        end
        // Unlimited instance keeps counting and saturates at 15.
        for (int i = 0; i < 12; i++) begin
            step();
            exp_beat = (6 + i > 15) ? 4'd15 : 4'(6 + i);
            vectors++;
            if ({gnt_a, beat_a} !== {3'b001, exp_beat}) begin
                miscompares++;
                $display("FAIL beat_saturate[%0d]: got gnt=%b beat=%0d expected gnt=001 beat=%0d", i, gnt_a, beat_a, exp_beat);
            end
        end
        last = 3'b001;
        step();
        vectors++;
        if ({gnt_a, sel_a, valid_a, beat_a} !== 10'b000_00_0_0000) begin
            miscompares++;
            $display("FAIL unlimited_release: got %b expected 0000000000", {gnt_a, sel_a, valid_a, beat_a});
        end
    endtask

    task automatic test_mid_burst();
        logic [9:0] exp_v;
        do_reset();
        req = 3'b010; ready = 1'b1;
        step();
        step();
        step();
        req = 3'b000;
        #1;
        exp_v = 10'b010_01_0_0010;
        vectors++;
        if ({gnt_a, sel_a, valid_a, beat_a} !== exp_v) begin
            miscompares++;
            $display("FAIL mid_drop_now: got %b expected %b", {gnt_a, sel_a, valid_a, beat_a}, exp_v);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            vectors++;
            if ({gnt_a, sel_a, valid_a, beat_a} !== exp_v) begin
                miscompares++;
                $display("FAIL mid_drop_hold[%0d]: got %b expected %b", i, {gnt_a, sel_a, valid_a, beat_a}, exp_v);
            end
        end
        rst = 1'b1; req = 3'b111;
        step();
        rst = 1'b0;
        exp_v = 10'b000_00_0_0000;
        vectors++;
        if ({gnt_a, sel_a, valid_a, beat_a} !== exp_v) begin
            miscompares++;
            $display("FAIL mid_reset: got %b expected %b", {gnt_a, sel_a, valid_a, beat_a}, exp_v);
        end
        // Pointer back at 0: with all requesting, ch0 wins.
        step();
        exp_v = 10'b001_00_1_0000;
        vectors++;
        if ({gnt_a, sel_a, valid_a, beat_a} !== exp_v) begin
            miscompares++;
            $display("FAIL mid_regrant: got %b expected %b", {gnt_a, sel_a, valid_a, beat_a}, exp_v);
        end
    endtask

    initial begin
        rst = 1'b1; req = 3'b000; last = 3'b000; ready = 1'b0;
        test_reset();
        test_single_request();
        test_round_robin();
        test_backpressure();
        test_burst_limit();
        test_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
